// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: pointer width, skid state encoding, gray/binary helpers.
package fifo_pkg;

  localparam int unsigned MAX_PTR_W = 16;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

  // Pointer width including the wrap bit
  function automatic int unsigned ptr_w(input int unsigned depth);
    return int'($clog2(depth)) + 1;
  endfunction

  function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Narrower pointers are zero-extended, which leaves the conversion exact
  function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
    logic [MAX_PTR_W-1:0] b;
    b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
    for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with no logic between stages; shared by both FIFO clock domains.
module sync_2ff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/wr_ingress_ctrl.sv
// Write-domain FIFO front end: 2-entry skid buffer, read-pointer sync, fill level.
// Optional high-water mark register enabled by defining WR_INGRESS_HWM_EN.
module wr_ingress_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned D_WIDTH   = 8,
  parameter int unsigned AF_THRESH = 6,
  parameter int unsigned PTR_W     = ptr_w(DEPTH)
) (
  input  logic               wclk,
  input  logic               reset,
  input  logic               s_valid,
  input  logic [D_WIDTH-1:0] s_data,
  output logic               s_ready,
  input  logic [PTR_W-1:0]   gray_r_ptr,
  output logic [PTR_W-1:0]   gray_r_ptr_syn,
  input  logic               full,
  input  logic [PTR_W-1:0]   bin_w_ptr,
  input  logic [PTR_W-1:0]   bin_r_ptr,
  output logic               w_en,
  output logic [D_WIDTH-1:0] w_data,
  output logic [PTR_W-1:0]   fill_level,
  output logic               almost_full,
  input  logic               hwm_clr,
  output logic [PTR_W-1:0]   hwm
);

  skid_state_e        state_q, state_d;
  logic [D_WIDTH-1:0] head_q, head_d;
  logic [D_WIDTH-1:0] tail_q, tail_d;
  logic               accept;
  logic               drain;

  assign accept = s_valid & s_ready;
  assign drain  = w_en;

  // State register; ready looks ahead so the producer stalls before the tail is needed
  always_ff @(posedge wclk) begin
    if (reset) begin
      state_q <= SKID_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      s_ready <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      s_ready <= (state_d != SKID_TWO);
    end
  end

  // Next-state and skid data movement; head always holds the oldest entry
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          state_d = SKID_ONE;
          head_d  = s_data;
        end
      end
      SKID_ONE: begin
        if (accept && drain) begin
          head_d = s_data;
        end else if (accept) begin
          state_d = SKID_TWO;
          tail_d  = s_data;
        end else if (drain) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        if (drain) begin
          state_d = SKID_ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  // Write request towards the FIFO port
  always_comb begin
    w_en = (state_q != SKID_EMPTY) & ~full;
  end

  assign w_data = head_q;

  // Modulo subtraction keeps the level correct across the wrap bit
  assign fill_level  = bin_w_ptr - bin_r_ptr;
  assign almost_full = (fill_level >= PTR_W'(AF_THRESH));

  sync_2ff #(
    .WIDTH (PTR_W)
  ) u_rptr_sync (
    .clk   (wclk),
    .reset (reset),
    .d     (gray_r_ptr),
    .q     (gray_r_ptr_syn)
  );

`ifdef WR_INGRESS_HWM_EN
  // Peak occupancy; clear wins over update
  always_ff @(posedge wclk) begin
    if (reset || hwm_clr) begin
      hwm <= '0;
    end else if (fill_level > hwm) begin
      hwm <= fill_level;
    end
  end
`else
  logic unused_hwm_clr;
  assign unused_hwm_clr = hwm_clr;
  assign hwm            = '0;
`endif

endmodule

// File: tb/tb_wr_ingress_ctrl.sv
// Scoreboard bench for wr_ingress_ctrl; the bench also models the write-pointer block.
module tb_wr_ingress_ctrl;

  logic       wclk = 1'b0;
  logic       reset = 1'b1;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready;
  logic [3:0] gray_r_ptr = 4'h0;
  logic [3:0] gray_r_ptr_syn;
  logic       full;
  logic [3:0] bin_w_ptr;
  logic [3:0] bin_r_ptr = 4'h0;
  logic       w_en;
  logic [7:0] w_data;
  logic [3:0] fill_level;
  logic       almost_full;
  logic       hwm_clr = 1'b0;
  logic [3:0] hwm;

  logic [3:0] wr_cnt = 4'h0;
  logic [3:0] w_off = 4'h0;
  int         n_vec = 0;
  int         n_miss = 0;
  int         n_wr = 0;
  int         n_accept = 0;
  logic [7:0] exp_q[$];

`ifdef WR_INGRESS_HWM_EN
  localparam logic [3:0] HWM_PEAK = 4'd7;
`else
  localparam logic [3:0] HWM_PEAK = 4'd0;
`endif

  always #5 wclk = ~wclk;

  // Write-pointer block model: pointer advances on each write, full at DEPTH entries
  always @(posedge wclk) if (w_en) wr_cnt <= wr_cnt + 4'd1;
  assign bin_w_ptr = wr_cnt + w_off;
  assign full      = (4'(bin_w_ptr - bin_r_ptr) == 4'd8);

  wr_ingress_ctrl dut (
    .wclk           (wclk),
    .reset          (reset),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .gray_r_ptr     (gray_r_ptr),
    .gray_r_ptr_syn (gray_r_ptr_syn),
    .full           (full),
    .bin_w_ptr      (bin_w_ptr),
    .bin_r_ptr      (bin_r_ptr),
    .w_en           (w_en),
    .w_data         (w_data),
    .fill_level     (fill_level),
    .almost_full    (almost_full),
    .hwm_clr        (hwm_clr),
    .hwm            (hwm)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Offer one beat from a falling edge; returns on a falling edge once accepted
  task automatic drive(input logic [7:0] d, output int waited);
    bit acc;
    acc     = 1'b0;
    waited  = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!acc && waited < 20) begin
      acc = s_ready;
      waited++;
      @(posedge wclk);
      if (acc) exp_q.push_back(d);
      @(negedge wclk);
    end
    if (acc) n_accept++;
    else begin
      n_vec++;
      n_miss++;
      $display("FAIL drive_timeout: data %0h not accepted within 20 cycles", d);
    end
  endtask

  // Move the modelled pointers just after a rising edge, return on the falling edge
  task automatic set_ptrs(input logic [3:0] w, input logic [3:0] r);
    @(posedge wclk);
    #1;
    bin_r_ptr = r;
    w_off     = w - wr_cnt;
    @(negedge wclk);
  endtask

  // Monitor: every presented write must match the oldest accepted beat
  initial forever begin
    @(negedge wclk);
    if (w_en === 1'b1) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_write: w_data %0h with nothing outstanding", w_data);
      end else begin
        chk("w_data_order", 32'(w_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int wr_base;

    // Reset held for three edges, then ready one edge after release
    repeat (3) begin
      @(negedge wclk);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_w_en", 32'(w_en), 32'd0);
      chk("rst_sync", 32'(gray_r_ptr_syn), 32'd0);
    end
    reset = 1'b0;
    @(negedge wclk);
    chk("ready_after_rst", 32'(s_ready), 32'd1);
    chk("idle_w_en", 32'(w_en), 32'd0);
    chk("idle_fill", 32'(fill_level), 32'd0);
    chk("idle_af", 32'(almost_full), 32'd0);
    chk("idle_hwm", 32'(hwm), 32'd0);

    // Single write appears the cycle after acceptance
    drive(8'hA5, waited);
    s_valid = 1'b0;
    chk("single_wait", 32'(waited), 32'd1);
    chk("single_w_en", 32'(w_en), 32'd1);
    chk("single_w_data", 32'(w_data), 32'hA5);
    @(negedge wclk);
    chk("single_w_en_low", 32'(w_en), 32'd0);

    // Burst into full: 8 writes land, 2 more park in the skid buffer
    set_ptrs(4'd0, 4'd0);
    wr_base  = n_wr;
    n_accept = 0;
    for (int i = 0; i < 10; i++) drive(8'(i), waited);
    s_valid = 1'b0;
    chk("burst_accepts", 32'(n_accept), 32'd10);
    chk("burst_writes", 32'(n_wr - wr_base), 32'd8);
    chk("burst_full", 32'(full), 32'd1);
    chk("burst_ready_low", 32'(s_ready), 32'd0);
    chk("burst_w_en_low", 32'(w_en), 32'd0);
    repeat (3) @(negedge wclk);
    chk("full_hold_ready", 32'(s_ready), 32'd0);
    chk("full_hold_w_en", 32'(w_en), 32'd0);
    chk("full_hold_data", 32'(w_data), 32'h08);
    set_ptrs(4'd8, 4'd2);
    repeat (4) @(negedge wclk);
    chk("drain_done", 32'(exp_q.size()), 32'd0);
    chk("drain_writes", 32'(n_wr - wr_base), 32'd10);
    chk("drain_ready", 32'(s_ready), 32'd1);
    chk("drain_fill", 32'(fill_level), 32'd8);

    // Synchroniser: visible on the 2nd edge, not the 1st
    @(posedge wclk);
    #1;
    gray_r_ptr = 4'b0001;
    @(posedge wclk);
    @(negedge wclk);
    chk("sync_edge1", 32'(gray_r_ptr_syn), 32'd0);
    @(negedge wclk);
    chk("sync_edge2", 32'(gray_r_ptr_syn), 32'd1);

    // Fill level across pointer wrap and almost_full threshold
    set_ptrs(4'b0010, 4'b1110);
    chk("wrap_fill4", 32'(fill_level), 32'd4);
    chk("wrap_af4", 32'(almost_full), 32'd0);
    set_ptrs(4'b0011, 4'b1110);
    chk("wrap_fill5", 32'(fill_level), 32'd5);
    chk("wrap_af5", 32'(almost_full), 32'd0);
    set_ptrs(4'b0100, 4'b1110);
    chk("wrap_fill6", 32'(fill_level), 32'd6);
    chk("wrap_af6", 32'(almost_full), 32'd1);
    set_ptrs(4'b0110, 4'b1110);
    chk("wrap_fill8", 32'(fill_level), 32'd8);
    chk("wrap_af8", 32'(almost_full), 32'd1);

    // Accept and drain together: no stall, order kept by the monitor
    set_ptrs(4'd0, 4'd0);
    for (int i = 0; i < 6; i++) begin
      drive(8'hC0 + 8'(i), waited);
      chk("ad_no_stall", 32'(waited), 32'd1);
      chk("ad_ready", 32'(s_ready), 32'd1);
      chk("ad_w_en", 32'(w_en), 32'd1);
    end
    s_valid = 1'b0;
    repeat (3) @(negedge wclk);
    chk("ad_done", 32'(exp_q.size()), 32'd0);

    // High-water mark: clear, peak at 7, read down, clear again
    hwm_clr = 1'b1;
    @(negedge wclk);
    hwm_clr = 1'b0;
    chk("hwm_clr0", 32'(hwm), 32'd0);
    set_ptrs(4'd7, 4'd0);
    set_ptrs(4'd3, 4'd0);
    chk("hwm_peak", 32'(hwm), 32'(HWM_PEAK));
    set_ptrs(4'd0, 4'd0);
    chk("hwm_hold", 32'(hwm), 32'(HWM_PEAK));
    hwm_clr = 1'b1;
    @(negedge wclk);
    hwm_clr = 1'b0;
    chk("hwm_clr1", 32'(hwm), 32'd0);

    // Reset with two beats parked behind full: discarded, no write issued
    set_ptrs(4'd8, 4'd0);
    drive(8'h11, waited);
    drive(8'h22, waited);
    s_valid = 1'b0;
    chk("pre_rst_ready", 32'(s_ready), 32'd0);
    reset = 1'b1;
    exp_q.delete();
    @(negedge wclk);
    chk("mid_rst_ready", 32'(s_ready), 32'd0);
    chk("mid_rst_w_en", 32'(w_en), 32'd0);
    set_ptrs(4'd0, 4'd0);
    chk("rst_hold_w_en", 32'(w_en), 32'd0);
    reset = 1'b0;
    @(negedge wclk);
    chk("post_rst_ready", 32'(s_ready), 32'd1);
    chk("post_rst_w_en", 32'(w_en), 32'd0);
    drive(8'h33, waited);
    s_valid = 1'b0;
    chk("post_rst_data", 32'(w_data), 32'h33);
    repeat (3) @(negedge wclk);
    chk("final_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
